// File: rtl/uart_tx_config_if.sv
// rtl/uart_tx_config_if.sv - producer-to-transmitter word stream
//
// Purpose: groups the valid/ready word handshake into a single port.
// Signals:
//   data_valid  producer -> transmitter  producer has a word
//   data_ready  transmitter -> producer  transmit FIFO not full
//   data_bits   producer -> transmitter  word, LSB sent first
interface uart_tx_config_if #(
    parameter int DATA_BITS_MAX = 8
);
    logic                     data_valid;
    logic                     data_ready;
    logic [DATA_BITS_MAX-1:0] data_bits;

    modport master (
        output data_valid,
        output data_bits,
        input  data_ready
    );

    modport slave (
        input  data_valid,
        input  data_bits,
        output data_ready
    );
endinterface

// File: rtl/uart_tx_config.sv
// rtl/uart_tx_config.sv - runtime-configurable UART transmitter with TX FIFO and CTS
//
// Purpose: serialises words from a small FIFO onto tx with a per-frame
// format (5..DATA_BITS_MAX data bits, none/even/odd/mark parity, 1 or 2
// stop bits) and a runtime baud divider. Frames start only when the
// synchronised cts_n is low; a started frame always completes.
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   stream           word stream (data_valid/data_ready/data_bits)
//   divider          clock cycles per bit, 0 behaves as 1
//   data_width       data bits per frame, clamped to 5..DATA_BITS_MAX
//   parity_mode      0 none, 1 even, 2 odd, 3 mark
//   two_stop         0 one stop bit, 1 two stop bits
//   cts_n            asynchronous clear-to-send, active-low
//   tx               serial line, idle high
//   busy             frame in progress or FIFO non-empty
//   fifo_level       occupied FIFO entries
module uart_tx_config #(
    parameter int DATA_BITS_MAX = 8,
    parameter int DIVIDER_BITS  = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                             clock,
    input  logic                             reset_n,
    uart_tx_config_if.slave                  stream,
    input  logic [DIVIDER_BITS-1:0]          divider,
    input  logic [3:0]                       data_width,
    input  logic [1:0]                       parity_mode,
    input  logic                             two_stop,
    input  logic                             cts_n,
    output logic                             tx,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state, state_nx;

    // Transmit FIFO
    logic [DATA_BITS_MAX-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [LVL_W-1:0]         level;
    logic                     push, load;

    // CTS synchroniser, reset to "not clear"
    logic cts_meta, cts_sync;

    // Frame datapath, all latched at load so the frame in flight ignores config changes
    logic [DIVIDER_BITS-1:0]  baud_cnt, bit_len;
    logic [DATA_BITS_MAX-1:0] shreg;
    logic [3:0]               data_left;
    logic                     par_en_q, par_bit_q, stop_left;

    // Load-time helpers
    logic [DIVIDER_BITS-1:0]  div_eff;
    logic [3:0]               width_eff;
    logic [DATA_BITS_MAX-1:0] head;
    logic                     head_xor, par_bit_nx;
    logic                     baud_tick, can_load;

    assign stream.data_ready = (level != LVL_W'(FIFO_DEPTH));
    assign push              = stream.data_valid && stream.data_ready;
    assign fifo_level        = level;
    assign busy              = (state != S_IDLE) || (level != '0);
    assign baud_tick         = (baud_cnt == '0);
    assign can_load          = (level != '0) && !cts_sync;

    always_comb begin
        div_eff = (divider == '0) ? DIVIDER_BITS'(1) : divider;
        if (data_width < 4'd5) begin
            width_eff = 4'd5;
        end else if (data_width > 4'(DATA_BITS_MAX)) begin
            width_eff = 4'(DATA_BITS_MAX);
        end else begin
            width_eff = data_width;
        end
        head     = mem[rd_ptr];
        // Parity covers only the bits actually sent
        head_xor = 1'b0;
        for (int i = 0; i < DATA_BITS_MAX; i++) begin
            if (i < int'(width_eff)) begin
                head_xor = head_xor ^ head[i];
            end
        end
        case (parity_mode)
            2'd1:    par_bit_nx = head_xor;
            2'd2:    par_bit_nx = ~head_xor;
            default: par_bit_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cts_meta <= 1'b1;
            cts_sync <= 1'b1;
        end else begin
            cts_meta <= cts_n;
            cts_sync <= cts_meta;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, load})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= stream.data_bits;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // tx is decoded from registered state only, so reset forces it high at once
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        tx       = 1'b1;
        case (state)
            S_IDLE: begin
                if (can_load) begin
                    load     = 1'b1;
                    state_nx = S_START;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (baud_tick) begin
                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                tx = shreg[0];
                if (baud_tick && (data_left == 4'd1)) begin
                    state_nx = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                tx = par_bit_q;
                if (baud_tick) begin
                    state_nx = S_STOP;
                end
            end
            S_STOP: begin
                // Chain straight into the next start bit when possible
                if (baud_tick && !stop_left) begin
                    if (can_load) begin
                        load     = 1'b1;
                        state_nx = S_START;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            baud_cnt  <= '0;
            bit_len   <= '0;
            shreg     <= '0;
            data_left <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b1;
            stop_left <= 1'b0;
        end else if (load) begin
            baud_cnt  <= div_eff - DIVIDER_BITS'(1);
            bit_len   <= div_eff - DIVIDER_BITS'(1);
            shreg     <= head;
            data_left <= width_eff;
            par_en_q  <= (parity_mode != 2'd0);
            par_bit_q <= par_bit_nx;
            stop_left <= two_stop;
        end else if (state != S_IDLE) begin
            if (baud_tick) begin
                baud_cnt <= bit_len;
                if (state == S_DATA) begin
                    shreg     <= shreg >> 1;
                    data_left <= data_left - 4'd1;
                end
                if (state == S_STOP) begin
                    stop_left <= 1'b0;
                end
            end else begin
                baud_cnt <= baud_cnt - DIVIDER_BITS'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_config.sv
// tb/tb_uart_tx_config.sv - self-checking bench for uart_tx_config
module tb_uart_tx_config;
    localparam int DBM   = 8;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] divider;
    logic [3:0]  data_width;
    logic [1:0]  parity_mode;
    logic        two_stop;
    logic        cts_n;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_level;

    int checks   = 0;
    int failures = 0;

    uart_tx_config_if #(.DATA_BITS_MAX(DBM)) bus ();

    uart_tx_config #(
        .DATA_BITS_MAX (DBM),
        .DIVIDER_BITS  (16),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .stream      (bus),
        .divider     (divider),
        .data_width  (data_width),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .cts_n       (cts_n),
        .tx          (tx),
        .busy        (busy),
        .fifo_level  (fifo_level)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO contents, expected per-cycle tx of the frame(s) in flight,
    // and the two-stage view of cts_n.
    logic [DBM-1:0] m_fifo[$];
    bit             m_line[$];
    bit             m_s1 = 1'b1, m_s2 = 1'b1;
    bit             m_acc = 1'b0;

    function automatic void build_frame(input logic [DBM-1:0] w);
        int d, wid;
        bit p;
        bit bits[$];
        d   = (divider == 16'd0) ? 1 : int'(divider);
        wid = int'(data_width);
        if (wid < 5) wid = 5;
        if (wid > DBM) wid = DBM;
        p = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < wid; i++) begin
            bits.push_back(w[i]);
            p = p ^ w[i];
        end
        case (parity_mode)
            2'd1: bits.push_back(p);
            2'd2: bits.push_back(!p);
            2'd3: bits.push_back(1'b1);
            default: ;
        endcase
        bits.push_back(1'b1);
        if (two_stop) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int r = 0; r < d; r++) m_line.push_back(bits[k]);
        end
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_fifo.delete();
            m_line.delete();
            m_s1  = 1'b1;
            m_s2  = 1'b1;
            m_acc = 1'b0;
        end else begin
            int sz;
            sz    = m_fifo.size();
            m_acc = bus.data_valid && (sz < DEPTH);
            if (m_line.size() != 0) void'(m_line.pop_front());
            if (m_line.size() == 0 && sz != 0 && !m_s2) build_frame(m_fifo.pop_front());
            if (m_acc) m_fifo.push_back(bus.data_bits);
            m_s2 = m_s1;
            m_s1 = cts_n;
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            chk("cyc_tx", int'(tx), (m_line.size() != 0) ? int'(m_line[0]) : 1);
            chk("cyc_busy", int'(busy), int'(m_line.size() != 0 || m_fifo.size() != 0));
            chk("cyc_level", int'(fifo_level), m_fifo.size());
            chk("cyc_ready", int'(bus.data_ready), int'(m_fifo.size() != DEPTH));
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_cfg(input int d, input int w, input int p, input bit ts);
        divider     = 16'(d);
        data_width  = 4'(w);
        parity_mode = 2'(p);
        two_stop    = ts;
    endtask

    task automatic push_word(input logic [DBM-1:0] w, output int waited);
        bus.data_valid = 1'b1;
        bus.data_bits  = w;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!m_acc && waited < 400);
        bus.data_valid = 1'b0;
        chk("push_accept", int'(m_acc), 1);
    endtask

    task automatic wait_fall;
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 2000) begin
            tick();
            n++;
        end
        chk("start_seen", int'(tx), 0);
    endtask

    // Samples each bit time in its middle, starting from the start bit
    task automatic capture(input int d, input int nb, output logic [15:0] bits);
        int cur, tgt;
        cur  = 0;
        bits = '0;
        wait_fall();
        for (int i = 0; i < nb; i++) begin
            tgt = i * d + d / 2;
            while (cur < tgt) begin
                tick();
                cur++;
            end
            bits[i] = tx;
        end
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        chk("drain_idle", int'(busy), 0);
    endtask

    initial begin
        logic [15:0] fr;
        int w, n, t, fall_n, acc_n;

        reset_n        = 1'b0;
        cts_n          = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_bits  = '0;
        set_cfg(4, 8, 0, 1'b0);
        repeat (3) tick();
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_level", int'(fifo_level), 0);
        chk("reset_ready", int'(bus.data_ready), 1);
        reset_n = 1'b1;
        tick();

        // 8N1, divider 4
        push_word(8'h55, w);
        capture(4, 10, fr);
        chk("f55_bits", int'(fr), 'h2AA);
        tick();
        chk("f55_busy_last", int'(busy), 1);
        tick();
        chk("f55_busy_end", int'(busy), 0);
        chk("f55_tx_end", int'(tx), 1);

        // 7E2, divider 3
        set_cfg(3, 7, 1, 1'b1);
        push_word(8'h41, w);
        capture(3, 11, fr);
        chk("f41_bits", int'(fr), 'h682);
        tick();
        chk("f41_busy_last", int'(busy), 1);
        tick();
        chk("f41_busy_end", int'(busy), 0);

        // 5O1, divider 2; upper bits ignored
        set_cfg(2, 5, 2, 1'b0);
        push_word(8'h1F, w);
        capture(2, 8, fr);
        chk("f1f_bits", int'(fr), 'hBE);
        push_word(8'hFF, w);
        capture(2, 8, fr);
        chk("fff_bits", int'(fr), 'hBE);

        // divider 0 -> 1, width 2 -> 5, mark parity
        set_cfg(0, 2, 3, 1'b0);
        push_word(8'h00, w);
        capture(1, 8, fr);
        chk("fmark_bits", int'(fr), 'hC0);

        // Full FIFO, six frames back-to-back
        set_cfg(8, 8, 0, 1'b0);
        cts_n = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 4; k++) push_word(8'h30 + 8'(k), w);
        chk("full_level", int'(fifo_level), 4);
        chk("full_ready", int'(bus.data_ready), 0);
        bus.data_valid = 1'b1;
        bus.data_bits  = 8'h34;
        cts_n  = 1'b0;
        n      = 0;
        fall_n = 0;
        acc_n  = 0;
        while (acc_n == 0 && n < 20) begin
            tick();
            n++;
            if (tx == 1'b0 && fall_n == 0) fall_n = n;
            if (m_acc) begin
                acc_n = n;
                bus.data_valid = 1'b0;
            end
        end
        bus.data_valid = 1'b0;
        chk("full_start_lat", fall_n, 3);
        chk("full_5th_accept", acc_n, 4);
        t = acc_n - fall_n;
        push_word(8'h35, w);
        t = t + w;
        while (busy && t < 2000) begin
            tick();
            t++;
        end
        chk("six_frames_len", t, 480);

        // CTS hold / release / mid-frame deassertion
        set_cfg(4, 8, 0, 1'b0);
        cts_n = 1'b1;
        repeat (3) tick();
        push_word(8'h12, w);
        push_word(8'h34, w);
        repeat (5) tick();
        chk("cts_hold_tx", int'(tx), 1);
        chk("cts_hold_busy", int'(busy), 1);
        chk("cts_hold_level", int'(fifo_level), 2);
        cts_n = 1'b0;
        n = 0;
        while (tx !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        chk("cts_start_lat", n, 3);
        repeat (8) tick();
        cts_n = 1'b1;
        repeat (32) tick();
        chk("cts_after_tx", int'(tx), 1);
        chk("cts_after_level", int'(fifo_level), 1);
        chk("cts_after_busy", int'(busy), 1);
        repeat (10) tick();
        chk("cts_held_tx", int'(tx), 1);
        chk("cts_held_level", int'(fifo_level), 1);
        cts_n = 1'b0;
        wait_idle();

        // Reset in the middle of DATA
        push_word(8'hA5, w);
        push_word(8'h11, w);
        wait_fall();
        repeat (10) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_tx", int'(tx), 1);
        chk("rst_mid_level", int'(fifo_level), 0);
        chk("rst_mid_ready", int'(bus.data_ready), 1);
        chk("rst_mid_busy", int'(busy), 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        set_cfg(4, 15, 0, 1'b0);
        push_word(8'hA5, w);
        capture(4, 10, fr);
        chk("fa5_bits", int'(fr), 'h34A);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
